// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : pong_ball_engine
//  Purpose  : Single-clock ball controller for the VGA pong driver. Owns the
//             ball position, direction, serve timing, paddle/border bounces
//             and score event pulses.
//  Option   : PONG_SPEEDUP_EN -- when defined, every paddle hit raises the
//             speed by one pixel per tick, saturating at MAX_SPEED.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
  parameter int W           = 10,
  parameter int BALL_SIZE   = 8,
  parameter int TICK_DIV    = 1000000,
  parameter int SPEED       = 1,
  parameter int MAX_SPEED   = 4,
  parameter int SERVE_TICKS = 60,
  parameter int START_H     = 316,
  parameter int START_V     = 236
) (
  input  logic         CLK_100MHz,
  input  logic         Reset,
  input  logic         run,
  input  logic [W-1:0] borderHmin,
  input  logic [W-1:0] borderHmax,
  input  logic [W-1:0] borderVmin,
  input  logic [W-1:0] borderVmax,
  input  logic [W-1:0] LHmin,
  input  logic [W-1:0] LHmax,
  input  logic [W-1:0] LVmin,
  input  logic [W-1:0] LVmax,
  input  logic [W-1:0] RHmin,
  input  logic [W-1:0] RHmax,
  input  logic [W-1:0] RVmin,
  input  logic [W-1:0] RVmax,
  output logic [W-1:0] BHmin,
  output logic [W-1:0] BHmax,
  output logic [W-1:0] BVmin,
  output logic [W-1:0] BVmax,
  output logic         scoreL,
  output logic         scoreR,
  output logic         hit,
  output logic         serving
);

  localparam int CW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int STW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam int SW  = $clog2(((MAX_SPEED > BALL_SIZE) ? MAX_SPEED : BALL_SIZE) + 1);
  // Two guard bits: one for overflow past the top of the W range, one sign
  // bit so a step below zero compares as negative instead of wrapping.
  localparam int XW  = W + 2;

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_MOVE  = 2'd1,
    S_SCORE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    tick_cnt_q;
  logic [STW-1:0]   serve_cnt_q;
  logic [SW-1:0]    speed_q;
  logic [W-1:0]     hmin_q, vmin_q;
  logic             dir_h_q, dir_v_q;   // 1 = increasing coordinate
  logic             score_l_q, score_r_q, hit_q, serving_q;

  logic             tick;
  logic [W-1:0]     hmax_cur, vmax_cur;
  logic signed [XW-1:0] spd_x, h_min_n, h_max_n, v_min_n, v_max_n;
  logic             hit_l, hit_r, goal_l, goal_r;
  logic [W-1:0]     hmin_d, vmin_d;
  logic             dir_h_d, dir_v_d;
  logic [SW-1:0]    speed_hit_d;

  function automatic logic signed [XW-1:0] ext(input logic [W-1:0] x);
    return signed'({2'b00, x});
  endfunction

  assign tick     = run && (tick_cnt_q == CW'(TICK_DIV - 1));
  assign hmax_cur = hmin_q + W'(BALL_SIZE - 1);
  assign vmax_cur = vmin_q + W'(BALL_SIZE - 1);

  // Movement tick divider; holds its count while the game is frozen.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      tick_cnt_q <= '0;
    end else if (run) begin
      if (tick_cnt_q == CW'(TICK_DIV - 1)) tick_cnt_q <= '0;
      else                                 tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Candidate next position, bounce and goal decisions for the current tick.
  always_comb begin
    spd_x   = signed'({{(XW - SW){1'b0}}, speed_q});
    h_min_n = dir_h_q ? ext(hmin_q) + spd_x : ext(hmin_q) - spd_x;
    v_min_n = dir_v_q ? ext(vmin_q) + spd_x : ext(vmin_q) - spd_x;
    h_max_n = h_min_n + XW'(BALL_SIZE - 1);
    v_max_n = v_min_n + XW'(BALL_SIZE - 1);

    hit_l = !dir_h_q && (h_min_n <= ext(LHmax)) && (hmin_q > LHmin) &&
            (vmax_cur >= LVmin) && (vmin_q <= LVmax);
    hit_r =  dir_h_q && (h_max_n >= ext(RHmin)) && (hmax_cur < RHmax) &&
            (vmax_cur >= RVmin) && (vmin_q <= RVmax);
    goal_r = !dir_h_q && !hit_l && (h_min_n <= ext(borderHmin));
    goal_l =  dir_h_q && !hit_r && (h_max_n >= ext(borderHmax));

    vmin_d  = v_min_n[W-1:0];
    dir_v_d = dir_v_q;
    if (!dir_v_q && (v_min_n <= ext(borderVmin))) begin
      vmin_d  = borderVmin + 1'b1;
      dir_v_d = 1'b1;
    end else if (dir_v_q && (v_max_n >= ext(borderVmax))) begin
      vmin_d  = borderVmax - W'(BALL_SIZE);
      dir_v_d = 1'b0;
    end

    hmin_d  = h_min_n[W-1:0];
    dir_h_d = dir_h_q;
    if (hit_l) begin
      hmin_d  = LHmax + 1'b1;
      dir_h_d = 1'b1;
    end else if (hit_r) begin
      hmin_d  = RHmin - W'(BALL_SIZE);
      dir_h_d = 1'b0;
    end

`ifdef PONG_SPEEDUP_EN
    speed_hit_d = (speed_q >= SW'(MAX_SPEED)) ? speed_q : speed_q + 1'b1;
`else
    speed_hit_d = speed_q;
`endif
  end

  // Game state machine: serve wait, movement, score hand-off; owns all outputs.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_SERVE;
      serve_cnt_q <= '0;
      speed_q     <= SW'(SPEED);
      hmin_q      <= W'(START_H);
      vmin_q      <= W'(START_V);
      dir_h_q     <= 1'b1;
      dir_v_q     <= 1'b1;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
      hit_q       <= 1'b0;
      serving_q   <= 1'b1;
    end else begin
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      hit_q     <= 1'b0;
      if (run) begin
        case (state_q)
          S_SERVE: begin
            if (tick) begin
              if (serve_cnt_q == STW'(SERVE_TICKS - 1)) begin
                serve_cnt_q <= '0;
                state_q     <= S_MOVE;
                serving_q   <= 1'b0;
              end else begin
                serve_cnt_q <= serve_cnt_q + 1'b1;
              end
            end
          end
          S_MOVE: begin
            if (tick) begin
              if (goal_l || goal_r) begin
                // Ball stays where it was; the next cycle recentres it.
                score_l_q <= goal_l;
                score_r_q <= goal_r;
                state_q   <= S_SCORE;
              end else begin
                hmin_q  <= hmin_d;
                vmin_q  <= vmin_d;
                dir_h_q <= dir_h_d;
                dir_v_q <= dir_v_d;
                if (hit_l || hit_r) begin
                  hit_q   <= 1'b1;
                  speed_q <= speed_hit_d;
                end
              end
            end
          end
          S_SCORE: begin
            hmin_q      <= W'(START_H);
            vmin_q      <= W'(START_V);
            dir_h_q     <= ~dir_h_q;
            speed_q     <= SW'(SPEED);
            serve_cnt_q <= '0;
            state_q     <= S_SERVE;
            serving_q   <= 1'b1;
          end
          default: begin
            state_q   <= S_SERVE;
            serving_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign BHmin   = hmin_q;
  assign BVmin   = vmin_q;
  assign BHmax   = hmax_cur;
  assign BVmax   = vmax_cur;
  assign scoreL  = score_l_q;
  assign scoreR  = score_r_q;
  assign hit     = hit_q;
  assign serving = serving_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_ball_engine
//  Purpose  : Directed self-checking bench for pong_ball_engine
//             (TICK_DIV=4, SERVE_TICKS=2, SPEED=1, 640x480 playfield).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_ball_engine;

  localparam int W = 10;
`ifdef PONG_SPEEDUP_EN
  localparam int POST_HIT_STEP = 2;
`else
  localparam int POST_HIT_STEP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         run = 1'b0;
  logic [W-1:0] bd_hmin, bd_hmax, bd_vmin, bd_vmax;
  logic [W-1:0] l_hmin, l_hmax, l_vmin, l_vmax;
  logic [W-1:0] r_hmin, r_hmax, r_vmin, r_vmax;
  logic [W-1:0] b_hmin, b_hmax, b_vmin, b_vmax;
  logic         score_l, score_r, hit, serving;

  int n_total = 0;
  int n_bad   = 0;

  pong_ball_engine #(
    .W(10), .BALL_SIZE(8), .TICK_DIV(4), .SPEED(1), .MAX_SPEED(4),
    .SERVE_TICKS(2), .START_H(316), .START_V(236)
  ) dut (
    .CLK_100MHz(clk), .Reset(rst_n), .run(run),
    .borderHmin(bd_hmin), .borderHmax(bd_hmax),
    .borderVmin(bd_vmin), .borderVmax(bd_vmax),
    .LHmin(l_hmin), .LHmax(l_hmax), .LVmin(l_vmin), .LVmax(l_vmax),
    .RHmin(r_hmin), .RHmax(r_hmax), .RVmin(r_vmin), .RVmax(r_vmax),
    .BHmin(b_hmin), .BHmax(b_hmax), .BVmin(b_vmin), .BVmax(b_vmax),
    .scoreL(score_l), .scoreR(score_r), .hit(hit), .serving(serving)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bd_hmin = 0;   bd_hmax = 639; bd_vmin = 0;   bd_vmax = 479;
    l_hmin  = 10;  l_hmax  = 17;  l_vmin  = 0;   l_vmax  = 5;
    r_hmin  = 620; r_hmax  = 627; r_vmin  = 0;   r_vmax  = 5;

    // Reset state
    #2 rst_n = 1'b0;
    cyc(3);
    check_val("rst_hmin", b_hmin, 316);
    check_val("rst_hmax", b_hmax, 323);
    check_val("rst_vmin", b_vmin, 236);
    check_val("rst_vmax", b_vmax, 243);
    check_val("rst_serving", serving, 1);
    check_val("rst_pulses", {score_l, score_r, hit}, 0);

    // Serve: two ticks at centre, then first step four cycles later
    rst_n = 1'b1; run = 1'b1;
    cyc(11);
    check_val("serve_hold_h", b_hmin, 316);
    check_val("serve_done", serving, 0);
    cyc(1);
    check_val("move1_h", b_hmin, 317);
    check_val("move1_v", b_vmin, 237);
    cyc(4);
    check_val("move2_h", b_hmin, 318);

    // Freeze: counter holds mid-count, resumes where it stopped
    cyc(1);
    run = 1'b0;
    cyc(20);
    check_val("freeze_h", b_hmin, 318);
    check_val("freeze_v", b_vmin, 238);
    check_val("freeze_pulses", {score_l, score_r, hit}, 0);
    run = 1'b1;
    cyc(2);
    check_val("resume_wait_h", b_hmin, 318);
    cyc(1);
    check_val("resume_step_h", b_hmin, 319);

    // Bottom border clamp
    cyc(4 * 232);
    check_val("pre_clamp_vmax", b_vmax, 478);
    check_val("pre_clamp_h", b_hmin, 551);
    cyc(4);
    check_val("clamp_vmax", b_vmax, 478);
    check_val("clamp_h", b_hmin, 552);
    cyc(4);
    check_val("after_clamp_vmin", b_vmin, 470);

    // Right-border goal -> scoreL, recentre, serve leftward, dirV kept (up)
    bd_hmax = 565;
    cyc(16);
    check_val("pre_goalL_h", b_hmin, 557);
    check_val("pre_goalL_score", score_l, 0);
    cyc(4);
    check_val("goalL_pulse", score_l, 1);
    check_val("goalL_other", score_r, 0);
    check_val("goalL_frozen_h", b_hmin, 557);
    check_val("goalL_frozen_v", b_vmin, 466);
    cyc(1);
    check_val("goalL_pulse_end", score_l, 0);
    check_val("goalL_serving", serving, 1);
    check_val("goalL_centre_h", b_hmin, 316);
    check_val("goalL_centre_v", b_vmin, 236);
    bd_hmax = 639;
    cyc(11);
    check_val("serveL_step_h", b_hmin, 315);
    check_val("serveL_step_v", b_vmin, 235);

    // Left paddle bounce
    l_hmin = 300; l_hmax = 307; l_vmin = 200; l_vmax = 263;
    cyc(4 * 7);
    check_val("pre_hit_h", b_hmin, 308);
    check_val("pre_hit_pulse", hit, 0);
    cyc(4);
    check_val("hit_pulse", hit, 1);
    check_val("hit_h", b_hmin, 308);
    check_val("hit_v", b_vmin, 227);
    cyc(1);
    check_val("hit_pulse_end", hit, 0);
    cyc(3);
    check_val("post_hit_h", b_hmin, 308 + POST_HIT_STEP);
    check_val("post_hit_v", b_vmin, 227 - POST_HIT_STEP);

    // Asynchronous reset mid-move
    rst_n = 1'b0;
    #1;
    check_val("arst_h", b_hmin, 316);
    check_val("arst_v", b_vmin, 236);
    check_val("arst_serving", serving, 1);
    check_val("arst_pulses", {score_l, score_r, hit}, 0);
    cyc(2);
    l_vmin = 0; l_vmax = 5; bd_hmax = 330;
    rst_n = 1'b1;

    // Quick scoreL to obtain a leftward serve, then left-border goal -> scoreR
    cyc(32);
    check_val("g_pre_h", b_hmin, 322);
    cyc(4);
    check_val("g_scoreL", score_l, 1);
    cyc(1);
    check_val("g_centre_h", b_hmin, 316);
    bd_hmax = 639; bd_hmin = 310;
    cyc(11);
    check_val("g_step_h", b_hmin, 315);
    check_val("g_step_v", b_vmin, 237);
    cyc(16);
    check_val("g_edge_h", b_hmin, 311);
    check_val("g_edge_noscore", score_r, 0);
    cyc(4);
    check_val("g_scoreR", score_r, 1);
    check_val("g_scoreR_other", score_l, 0);
    check_val("g_scoreR_frozen_h", b_hmin, 311);
    check_val("g_scoreR_frozen_v", b_vmin, 241);
    cyc(1);
    check_val("g_scoreR_end", score_r, 0);
    check_val("g_recentre_h", b_hmin, 316);
    check_val("g_recentre_v", b_vmin, 236);
    cyc(11);
    check_val("g_serveR_h", b_hmin, 317);
    check_val("g_serveR_v", b_vmin, 237);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
